// File: rtl/vc_link_arbiter_pkg.sv
// Shared types and sizing for the VC link arbiter slice.
// VN and DW come from the `VN / `DW macros (defaults 4 and 16 when not set by the build).
// Optional feature: define VC_ARB_PKT_LOCK_EN for wormhole packet locking (see vc_link_arbiter.sv).
`ifndef VN
`define VN 4
`endif
`ifndef DW
`define DW 16
`endif

package vc_link_arbiter_pkg;

  localparam int VN      = `VN;
  localparam int DW      = `DW;
  // Downstream buffer depth per VC; reset value and ceiling of each credit counter.
  localparam int CREDITS = 4;
  localparam int CW      = $clog2(CREDITS + 1);
  localparam int IW      = (VN > 1) ? $clog2(VN) : 1;

  typedef logic [VN-1:0] vc_onehot_t;
  typedef logic [DW-1:0] flit_t;
  typedef logic [CW-1:0] credit_t;
  typedef logic [IW-1:0] vc_idx_t;

  // Packet-lock state encoding (two-state machine: link free or held by one VC).
  localparam logic [0:0] LK_FREE = 1'b0;
  localparam logic [0:0] LK_HELD = 1'b1;

  // Round-robin successor: (k+1) mod VN, valid for non-power-of-two VN.
  function automatic vc_idx_t next_vc(input vc_idx_t k);
    if (k == vc_idx_t'(VN - 1)) begin
      return '0;
    end
    return k + vc_idx_t'(1);
  endfunction

endpackage

// File: rtl/vc_link_arbiter_if.sv
// Bundle of the VC-buffer side, link side and credit side of the arbiter.
//
// Handshake rules (both sides):
//   - Upstream VC i: a flit moves when in_valid_i[i] & in_ready_o[i] on a rising clk edge.
//     in_ready_o is combinational from in_valid_i, credits and ready_i; at most one bit is set.
//     Upstream keeps in_data_i/in_last_i of VC i stable until it is taken.
//   - Link: a flit moves when valid_o & ready_i on a rising clk edge. While valid_o & ~ready_i
//     the arbiter holds vc_o/data_o stable. vc_o is one-hot while valid_o=1 and zero otherwise.
//   - credit_i[i]: single-cycle pulse, one downstream slot of VC i freed.
// The slave modport is the arbiter view; master is the driving environment.
interface vc_link_arbiter_if;
  import vc_link_arbiter_pkg::*;

  vc_onehot_t          in_valid_i;
  logic [VN*DW-1:0]    in_data_i;
  vc_onehot_t          in_last_i;
  vc_onehot_t          in_ready_o;
  vc_onehot_t          vc_o;
  flit_t               data_o;
  logic                valid_o;
  logic                ready_i;
  vc_onehot_t          credit_i;
  logic [VN*CW-1:0]    credit_o;
  // Debug view of the packet-lock state machine (held at zero when locking is compiled out).
  logic                dbg_lock_state_o;
  vc_idx_t             dbg_lock_vc_o;

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, ready_i, credit_i,
    output in_ready_o, vc_o, data_o, valid_o, credit_o, dbg_lock_state_o, dbg_lock_vc_o
  );

  modport master (
    output in_valid_i, in_data_i, in_last_i, ready_i, credit_i,
    input  in_ready_o, vc_o, data_o, valid_o, credit_o, dbg_lock_state_o, dbg_lock_vc_o
  );

endinterface

// File: rtl/vc_link_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin picker.
// Searches req from ptr upward (mod N); the first set request wins. Reusable for switch allocation.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  // Rotating priority scan starting at the pointer.
  always_comb begin
    int unsigned v_idx;
    v_idx     = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int o = 0; o < N; o++) begin
      v_idx = (int'(i_ptr) + o) % N;
      if (!o_any && i_req[v_idx]) begin
        o_any        = 1'b1;
        o_gnt[v_idx] = 1'b1;
        o_gnt_idx    = IW'(v_idx);
      end
    end
  end

endmodule

// File: rtl/vc_link_arbiter.sv
// vc_link_arbiter: shares one output link among VN virtual channels.
// Round-robin over per-VC FIFOs, gated by per-VC downstream credits; one output register stage.
// Optional macro VC_ARB_PKT_LOCK_EN: wormhole lock, a non-tail flit holds the link for its VC
// until that VC's tail flit is granted. Without it in_last_i is ignored and flits interleave.
module vc_link_arbiter
  import vc_link_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  vc_link_arbiter_if.slave  lnk
);

  logic        r_valid;
  vc_onehot_t  r_vc;
  flit_t       r_data;
  credit_t     r_credit [VN];
  vc_idx_t     r_ptr;

  logic        w_load;
  vc_onehot_t  w_lock_mask;
  vc_onehot_t  w_elig;
  vc_onehot_t  w_req;
  vc_onehot_t  w_gnt;
  vc_idx_t     w_gnt_idx;
  logic        w_any;
  flit_t       w_sel_data;

  // The output register can take a new flit when empty or when the sink takes the current one.
  // Reset blocks grants so no credit is spent on a flit that would be dropped.
  assign w_load = ~rst & (~r_valid | lnk.ready_i);

`ifdef VC_ARB_PKT_LOCK_EN
  logic [0:0] r_lock_state;
  vc_idx_t    r_lock_vc;

  // While a packet holds the link, only its VC may compete (even with zero credit: link idles).
  always_comb begin
    w_lock_mask = '1;
    if (r_lock_state == LK_HELD) begin
      w_lock_mask            = '0;
      w_lock_mask[r_lock_vc] = 1'b1;
    end
  end

  // Lock follows every grant: a non-tail flit holds the link, a tail (or single-flit packet) frees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_state <= LK_FREE;
      r_lock_vc    <= '0;
    end else if (w_any) begin
      r_lock_vc    <= w_gnt_idx;
      r_lock_state <= lnk.in_last_i[w_gnt_idx] ? LK_FREE : LK_HELD;
    end
  end

  assign lnk.dbg_lock_state_o = r_lock_state;
  assign lnk.dbg_lock_vc_o    = r_lock_vc;
`else
  logic w_unused_last;

  // No packet locking: every VC competes every cycle and tail markers carry no meaning here.
  always_comb begin
    w_lock_mask = '1;
  end

  assign w_unused_last        = ^lnk.in_last_i;
  assign lnk.dbg_lock_state_o = LK_FREE;
  assign lnk.dbg_lock_vc_o    = '0;
`endif

  // A VC is eligible with a flit waiting, downstream space and (if locking) the lock.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < VN; i++) begin
      w_elig[i] = lnk.in_valid_i[i] & (r_credit[i] != '0) & w_lock_mask[i];
    end
  end

  assign w_req = w_load ? w_elig : '0;

  rr_arbiter #(
    .N  (VN),
    .IW (IW)
  ) u_rr (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // Grant doubles as the upstream pop strobe in the same cycle.
  assign lnk.in_ready_o = w_gnt;

  // Mux the granted VC's flit out of the flattened input bus.
  always_comb begin
    w_sel_data = '0;
    if (w_any) begin
      w_sel_data = lnk.in_data_i[int'(w_gnt_idx)*DW +: DW];
    end
  end

  // Output stage: reload on w_load, otherwise hold the stalled flit unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_vc    <= '0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      r_vc    <= w_gnt;
      r_data  <= w_sel_data;
    end
  end

  assign lnk.valid_o = r_valid;
  assign lnk.vc_o    = r_vc;
  assign lnk.data_o  = r_data;

  // Pointer moves past the winner; unchanged when nothing was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= next_vc(w_gnt_idx);
    end
  end

  // Credit counters: grant spends one, a return pulse refunds one, both together cancel.
  // A refund on a full counter is clamped at CREDITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VN; i++) begin
        r_credit[i] <= credit_t'(CREDITS);
      end
    end else begin
      for (int i = 0; i < VN; i++) begin
        if (lnk.credit_i[i] && !w_gnt[i]) begin
          if (r_credit[i] != credit_t'(CREDITS)) begin
            r_credit[i] <= r_credit[i] + credit_t'(1);
          end
        end else if (w_gnt[i] && !lnk.credit_i[i]) begin
          r_credit[i] <= r_credit[i] - credit_t'(1);
        end
      end
    end
  end

  // Flatten the counters onto the credit_o bus, VC i in bits [i*CW +: CW].
  always_comb begin
    lnk.credit_o = '0;
    for (int i = 0; i < VN; i++) begin
      lnk.credit_o[i*CW +: CW] = r_credit[i];
    end
  end

`ifndef SYNTHESIS
  // A refund while the counter is already full means downstream returned more than it was given.
  always_ff @(posedge clk) begin
    for (int i = 0; i < VN; i++) begin
      if (!rst && lnk.credit_i[i] && !w_gnt[i]) begin
        assert (r_credit[i] != credit_t'(CREDITS))
          else $warning("vc_link_arbiter: credit return overflow on VC %0d", i);
      end
    end
  end
`endif

endmodule
